// File: rtl/decode_stage_ctrl.sv
// ============================================================================
// Module   : decode_stage_ctrl
// Brief    : RV64 decode-stage controller with format decode, immediate
//            generation and a 2-entry skid buffer toward execute.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_imm,
    output logic [2:0]      id_fmt,
    output logic            id_illegal
);

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_if_ready;

    logic [31:0]     r_e0_instr, r_e1_instr;
    logic [XLEN-1:0] r_e0_pc,    r_e1_pc;
    logic [XLEN-1:0] r_e0_imm,   r_e1_imm;
    logic [2:0]      r_e0_fmt,   r_e1_fmt;
    logic            r_e0_ill,   r_e1_ill;

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic [6:0]      w_opcode;
    logic            w_accept;
    logic            w_pop;
    logic            w_load0_new;
    logic            w_load0_from1;
    logic            w_load1_new;

    assign w_opcode = if_instr[6:0];

    always_comb begin
        w_fmt = c_FMT_ILL;
        w_ill = 1'b1;
        w_imm = '0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: begin
                w_fmt = c_FMT_I;
                w_ill = 1'b0;
                w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            7'b0100011: begin
                w_fmt = c_FMT_S;
                w_ill = 1'b0;
                w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt = c_FMT_B;
                w_ill = 1'b0;
                w_imm = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt = c_FMT_U;
                w_ill = 1'b0;
                w_imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt = c_FMT_J;
                w_ill = 1'b0;
                w_imm = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                w_fmt = c_FMT_R;
                w_ill = 1'b0;
            end
            default: ;
        endcase
    end

    // Flush masks the accept so a beat offered in the redirect cycle is dropped.
    assign w_accept = if_valid & r_if_ready & ~flush;
    assign w_pop    = (r_state != ST_EMPTY) & id_ready;

    always_comb begin
        w_state_next  = r_state;
        w_load0_new   = 1'b0;
        w_load0_from1 = 1'b0;
        w_load1_new   = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ST_ONE;
                        w_load0_new  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load0_new = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_FULL;
                        w_load1_new  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_next  = ST_ONE;
                        w_load0_from1 = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_if_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_if_ready <= (w_state_next != ST_FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e0_instr <= '0;
            r_e0_pc    <= '0;
            r_e0_imm   <= '0;
            r_e0_fmt   <= '0;
            r_e0_ill   <= 1'b0;
            r_e1_instr <= '0;
            r_e1_pc    <= '0;
            r_e1_imm   <= '0;
            r_e1_fmt   <= '0;
            r_e1_ill   <= 1'b0;
        end else begin
            if (w_load0_new) begin
                r_e0_instr <= if_instr;
                r_e0_pc    <= if_pc;
                r_e0_imm   <= w_imm;
                r_e0_fmt   <= w_fmt;
                r_e0_ill   <= w_ill;
            end else if (w_load0_from1) begin
                r_e0_instr <= r_e1_instr;
                r_e0_pc    <= r_e1_pc;
                r_e0_imm   <= r_e1_imm;
                r_e0_fmt   <= r_e1_fmt;
                r_e0_ill   <= r_e1_ill;
            end
            if (w_load1_new) begin
                r_e1_instr <= if_instr;
                r_e1_pc    <= if_pc;
                r_e1_imm   <= w_imm;
                r_e1_fmt   <= w_fmt;
                r_e1_ill   <= w_ill;
            end
        end
    end

    assign if_ready   = r_if_ready;
    assign id_valid   = (r_state != ST_EMPTY);
    assign id_instr   = r_e0_instr;
    assign id_pc      = r_e0_pc;
    assign id_imm     = r_e0_imm;
    assign id_fmt     = r_e0_fmt;
    assign id_illegal = r_e0_ill;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_ctrl.sv
// ============================================================================
// Module   : tb_decode_stage_ctrl
// Brief    : Directed self-checking bench for decode_stage_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_fmt;
    logic            id_illegal;

    int checks = 0;
    int errors = 0;

    decode_stage_ctrl #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_imm     (id_imm),
        .id_fmt     (id_fmt),
        .id_illegal (id_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [31:0] instr, input logic [63:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        check({tag, ".valid"}, {63'd0, id_valid}, 64'd1);
        check({tag, ".instr"}, {32'd0, id_instr}, {32'd0, instr});
        check({tag, ".pc"}, id_pc, pc);
        check({tag, ".imm"}, id_imm, imm);
        check({tag, ".fmt"}, {61'd0, id_fmt}, {61'd0, fmt});
        check({tag, ".ill"}, {63'd0, id_illegal}, {63'd0, ill});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        present(1'b0, 32'd0, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst.valid", {63'd0, id_valid}, 64'd0);
        check("rst.ready", {63'd0, if_ready}, 64'd1);
        check("rst.instr", {32'd0, id_instr}, 64'd0);
        check("rst.pc", id_pc, 64'd0);
        check("rst.imm", id_imm, 64'd0);
        check("rst.fmt", {61'd0, id_fmt}, 64'd0);
        check("rst.ill", {63'd0, id_illegal}, 64'd0);

        // Single addi, then back-to-back U/J/B/S with id_ready high
        id_ready = 1'b1;
        present(1'b1, 32'hFFF00093, 64'h1000);
        step();
        check_head("addi", 32'hFFF00093, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        present(1'b1, 32'h800000B7, 64'h1004);
        step();
        check_head("lui", 32'h800000B7, 64'h1004, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        present(1'b1, 32'hFFDFF06F, 64'h1008);
        step();
        check_head("jal", 32'hFFDFF06F, 64'h1008, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
        present(1'b1, 32'h00000463, 64'h100C);
        step();
        check_head("beq", 32'h00000463, 64'h100C, 64'h8, 3'd3, 1'b0);
        present(1'b1, 32'hFE20AC23, 64'h1010);
        step();
        check_head("sw", 32'hFE20AC23, 64'h1010, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        present(1'b0, 32'd0, 64'd0);
        step();
        check("drain.valid", {63'd0, id_valid}, 64'd0);

        // Back-pressure: continuous stream, execute stalled
        id_ready = 1'b0;
        present(1'b1, 32'h00500093, 64'h2000);
        step();
        check("bp1.ready", {63'd0, if_ready}, 64'd1);
        check("bp1.pc", id_pc, 64'h2000);
        present(1'b1, 32'h00A00113, 64'h2004);
        step();
        check("bp2.ready", {63'd0, if_ready}, 64'd0);
        check("bp2.pc", id_pc, 64'h2000);
        present(1'b1, 32'h00F00193, 64'h2008);
        step();
        check("bp3.ready", {63'd0, if_ready}, 64'd0);
        check_head("bp3.hold", 32'h00500093, 64'h2000, 64'd5, 3'd1, 1'b0);
        id_ready = 1'b1;
        step();
        check("bp4.ready", {63'd0, if_ready}, 64'd1);
        check_head("bp4.second", 32'h00A00113, 64'h2004, 64'd10, 3'd1, 1'b0);
        step();
        check_head("bp5.third", 32'h00F00193, 64'h2008, 64'd15, 3'd1, 1'b0);
        present(1'b0, 32'd0, 64'd0);
        step();
        check("bp6.valid", {63'd0, id_valid}, 64'd0);

        // Flush with a full buffer and a beat on offer
        id_ready = 1'b0;
        present(1'b1, 32'h00500093, 64'h2000);
        step();
        present(1'b1, 32'h00A00113, 64'h2004);
        step();
        check("fl.full", {63'd0, if_ready}, 64'd0);
        present(1'b1, 32'h00100213, 64'h3000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        present(1'b0, 32'd0, 64'd0);
        check("fl1.valid", {63'd0, id_valid}, 64'd0);
        check("fl1.ready", {63'd0, if_ready}, 64'd1);
        step();
        check("fl1.gone", {63'd0, id_valid}, 64'd0);

        // Flush while ready: offered beat still discarded
        present(1'b1, 32'h00500093, 64'h2000);
        step();
        present(1'b1, 32'h00100213, 64'h3000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        present(1'b0, 32'd0, 64'd0);
        check("fl2.valid", {63'd0, id_valid}, 64'd0);
        check("fl2.ready", {63'd0, if_ready}, 64'd1);
        step();
        check("fl2.gone", {63'd0, id_valid}, 64'd0);

        // Illegal opcode and an R-type
        id_ready = 1'b1;
        present(1'b1, 32'h0000007F, 64'h4000);
        step();
        check_head("ill", 32'h0000007F, 64'h4000, 64'd0, 3'd7, 1'b1);
        present(1'b1, 32'h802081B3, 64'h4004);
        step();
        check_head("rtype", 32'h802081B3, 64'h4004, 64'd0, 3'd0, 1'b0);
        present(1'b0, 32'd0, 64'd0);
        step();

        // Asynchronous reset while full
        id_ready = 1'b0;
        present(1'b1, 32'hFFF00093, 64'h5000);
        step();
        present(1'b1, 32'h800000B7, 64'h5004);
        step();
        check("ar.full", {63'd0, if_ready}, 64'd0);
        present(1'b0, 32'd0, 64'd0);
        #1 rst = 1'b1;
        #1;
        check("ar.valid", {63'd0, id_valid}, 64'd0);
        check("ar.ready", {63'd0, if_ready}, 64'd1);
        check("ar.pc", id_pc, 64'd0);
        check("ar.imm", id_imm, 64'd0);
        check("ar.instr", {32'd0, id_instr}, 64'd0);
        #1 rst = 1'b0;
        step();
        check("ar2.valid", {63'd0, id_valid}, 64'd0);
        check("ar2.ready", {63'd0, if_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
